// File: rtl/gcd_pkg.sv
// Shared types for the GCD engine: controller states, algorithm modes and datapath strobes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package gcd_pkg;

  // Controller states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    SUB   = 3'd2,
    ALIGN = 3'd3,
    STEIN = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Algorithm select carried on mode_in
  localparam logic MODE_SUB   = 1'b0;
  localparam logic MODE_STEIN = 1'b1;

  // Operation the datapath applies to its a/b/k registers this cycle
  typedef enum logic [2:0] {
    OP_HOLD  = 3'd0,
    OP_LOAD  = 3'd1,
    OP_SUB   = 3'd2,
    OP_ALIGN = 3'd3,
    OP_STEIN = 3'd4
  } dp_op_t;

  // Source for the result register (RES_HOLD keeps the previous result)
  typedef enum logic [1:0] {
    RES_HOLD  = 2'd0,
    RES_OR    = 2'd1,
    RES_A     = 2'd2,
    RES_SHIFT = 2'd3
  } res_sel_t;

endpackage

// File: rtl/gcd_datapath.sv
// GCD datapath: a/b/k registers, comparator, subtractors, shifters and result register.
// Latency: each strobe takes effect at the next clock edge; status flags are combinational.
// Backpressure: none here; the controller decides when to step or load.
module gcd_datapath
  import gcd_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  dp_op_t           op,
  input  res_sel_t         res_sel,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             a_zero,
  output logic             b_zero,
  output logic             a_eq_b,
  output logic             a_odd,
  output logic             b_odd,
  output logic [WIDTH-1:0] result
);

  localparam int K_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [K_W-1:0]   k_q;
  logic             a_gt_b;
  logic [WIDTH-1:0] a_minus_b;
  logic [WIDTH-1:0] b_minus_a;

  // Only the smaller operand is ever subtracted from the larger, so neither difference wraps
  assign a_minus_b = a_q - b_q;
  assign b_minus_a = b_q - a_q;
  assign a_gt_b    = (a_q > b_q);
  assign a_eq_b    = (a_q == b_q);
  assign a_zero    = (a_q == '0);
  assign b_zero    = (b_q == '0);
  assign a_odd     = a_q[0];
  assign b_odd     = b_q[0];

  // Operand registers and the common power-of-two exponent k
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q <= '0;
      b_q <= '0;
      k_q <= '0;
    end else begin
      case (op)
        OP_LOAD: begin
          a_q <= a_in;
          b_q <= b_in;
          k_q <= '0;
        end
        OP_SUB: begin
          if (a_gt_b) begin
            a_q <= a_minus_b;
          end else if (!a_eq_b) begin
            b_q <= b_minus_a;
          end
        end
        OP_ALIGN: begin
          a_q <= a_q >> 1;
          b_q <= b_q >> 1;
          k_q <= k_q + K_W'(1);
        end
        OP_STEIN: begin
          // Rule order matters: strip factors of two before any subtraction
          if (!a_odd) begin
            a_q <= a_q >> 1;
          end else if (!b_odd) begin
            b_q <= b_q >> 1;
          end else if (a_gt_b) begin
            a_q <= b_q;
            b_q <= a_minus_b;
          end else begin
            b_q <= b_minus_a;
          end
        end
        default: ;
      endcase
    end
  end

  // Result register; holds its value until the next completed operation
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result <= '0;
    end else begin
      case (res_sel)
        RES_OR:    result <= a_q | b_q;
        RES_A:     result <= a_q;
        RES_SHIFT: result <= a_q << k_q;
        default:   ;
      endcase
    end
  end

endmodule

// File: rtl/gcd_engine.sv
// GCD engine: subtractive or binary GCD with zero-operand error, iteration count and abort.
// Latency: accept, 1 check cycle, N compute cycles, then out_valid (2 cycles for zero operands).
// Backpressure: result held in DONE until out_ready; in_ready only while idle.
module gcd_engine
  import gcd_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             mode_in,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] gcd_out,
  output logic             err,
  output logic [CNT_W-1:0] iter_count
);

  state_t           state_q;
  state_t           state_nxt;
  dp_op_t           dp_op;
  res_sel_t         res_sel;
  logic             mode_q;
  logic [CNT_W-1:0] iter_q;
  logic [CNT_W-1:0] iter_inc;
  logic             cnt_en;
  logic             out_ld;
  logic             err_nxt;
  logic             a_zero;
  logic             b_zero;
  logic             a_eq_b;
  logic             a_odd;
  logic             b_odd;

  gcd_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk    (clk),
    .rst    (rst),
    .op     (dp_op),
    .res_sel(res_sel),
    .a_in   (a_in),
    .b_in   (b_in),
    .a_zero (a_zero),
    .b_zero (b_zero),
    .a_eq_b (a_eq_b),
    .a_odd  (a_odd),
    .b_odd  (b_odd),
    .result (gcd_out)
  );

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign iter_inc  = (&iter_q) ? iter_q : iter_q + CNT_W'(1);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state and datapath steering; abort beats completion in every compute state
  always_comb begin
    state_nxt = state_q;
    dp_op     = OP_HOLD;
    res_sel   = RES_HOLD;
    cnt_en    = 1'b0;
    out_ld    = 1'b0;
    err_nxt   = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          dp_op     = OP_LOAD;
          state_nxt = CHECK;
        end
      end
      CHECK: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (a_zero || b_zero) begin
          res_sel   = RES_OR;
          out_ld    = 1'b1;
          err_nxt   = a_zero && b_zero;
          state_nxt = DONE;
        end else if (mode_q == MODE_STEIN) begin
          state_nxt = ALIGN;
        end else begin
          state_nxt = SUB;
        end
      end
      SUB: begin
        if (abort) begin
          state_nxt = IDLE;
        end else begin
          cnt_en = 1'b1;
          if (a_eq_b) begin
            res_sel   = RES_A;
            out_ld    = 1'b1;
            state_nxt = DONE;
          end else begin
            dp_op = OP_SUB;
          end
        end
      end
      ALIGN: begin
        if (abort) begin
          state_nxt = IDLE;
        end else begin
          cnt_en = 1'b1;
          if (!a_odd && !b_odd) begin
            dp_op = OP_ALIGN;
          end else begin
            state_nxt = STEIN;
          end
        end
      end
      STEIN: begin
        if (abort) begin
          state_nxt = IDLE;
        end else begin
          cnt_en = 1'b1;
          if (b_zero) begin
            res_sel   = RES_SHIFT;
            out_ld    = 1'b1;
            state_nxt = DONE;
          end else begin
            dp_op = OP_STEIN;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Captured algorithm mode and running iteration counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q <= MODE_SUB;
      iter_q <= '0;
    end else if (dp_op == OP_LOAD) begin
      mode_q <= mode_in;
      iter_q <= '0;
    end else if (cnt_en) begin
      iter_q <= iter_inc;
    end
  end

  // Published status; the terminating compute cycle is included in the count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err        <= 1'b0;
      iter_count <= '0;
    end else if (out_ld) begin
      err        <= err_nxt;
      iter_count <= cnt_en ? iter_inc : iter_q;
    end
  end

endmodule

// File: tb/tb_gcd_engine.sv
// Testbench for gcd_engine: directed cases plus randomized operands against a reference model.
// Latency: measured per operation and compared with the model's iteration count.
// Backpressure: exercised by holding out_ready low while the result is pending.
module tb_gcd_engine;

  localparam int WIDTH  = 16;
  localparam int CNT_W  = 16;
  localparam int BUDGET = 600;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a_in = '0;
  logic [WIDTH-1:0] b_in = '0;
  logic             mode_in = 1'b0;
  logic             abort = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] gcd_out;
  logic             err;
  logic [CNT_W-1:0] iter_count;

  int n_vec = 0;
  int n_err = 0;

  gcd_engine #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .mode_in   (mode_in),
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .gcd_out   (gcd_out),
    .err       (err),
    .iter_count(iter_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: Euclid by remainder
  function automatic int ref_gcd(input int a, input int b);
    int x = a;
    int y = b;
    int t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Reference: compute cycles for either algorithm
  function automatic int ref_iter(input int a, input int b, input bit m);
    int x = a;
    int y = b;
    int t;
    int cnt = 0;
    if (a == 0 || b == 0) return 0;
    if (!m) begin
      // repeated subtraction until equal costs the sum of Euclid quotients
      while (y != 0) begin
        cnt += x / y;
        t = x % y;
        x = y;
        y = t;
      end
      return cnt;
    end
    while ((x % 2 == 0) && (y % 2 == 0)) begin
      x = x / 2;
      y = y / 2;
      cnt++;
    end
    cnt++;  // the cycle that finds an odd operand
    forever begin
      cnt++;
      if (y == 0) break;
      if (x % 2 == 0) x = x / 2;
      else if (y % 2 == 0) y = y / 2;
      else if (x > y) begin
        t = x - y;
        x = y;
        y = t;
      end else y = y - x;
    end
    return cnt;
  endfunction

  // Count falling edges after acceptance until out_valid; -1 when the budget runs out
  task automatic wait_done(input int budget, output int lat);
    lat = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic m, input int hold,
                       output logic [15:0] g, output logic e, output logic [15:0] it,
                       output int lat);
    @(negedge clk);
    in_valid = 1'b1;
    a_in     = a;
    b_in     = b;
    mode_in  = m;
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_done(BUDGET, lat);
    g  = gcd_out;
    e  = err;
    it = iter_count;
    if (lat < 0) begin
      // recover a stuck engine so the remaining vectors still run
      rst = 1'b0;
      #1 rst = 1'b1;
    end else begin
      repeat (hold) @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
    end
  endtask

  task automatic run_check(input string tag, input int a, input int b, input bit m);
    logic [15:0] g;
    logic [15:0] it;
    logic        e;
    int          lat;
    int          exp_it;
    exp_it = ref_iter(a, b, m);
    do_op(16'(a), 16'(b), m, 0, g, e, it, lat);
    check_val({tag, "_gcd"}, 32'(g), 32'(ref_gcd(a, b)));
    check_val({tag, "_err"}, 32'(e), 32'(a == 0 && b == 0));
    check_val({tag, "_iter"}, 32'(it), 32'(exp_it));
    check_val({tag, "_lat"}, 32'(lat), 32'(exp_it + 2));
  endtask

  initial begin
    logic [15:0] g;
    logic [15:0] it;
    logic        e;
    int          lat;
    int          ra;
    int          rb;
    bit          rm;

    // Reset values while held in reset
    #12;
    check_val("rst_in_ready", 32'(in_ready), 32'd1);
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_gcd", 32'(gcd_out), 32'd0);
    check_val("rst_err", 32'(err), 32'd0);
    check_val("rst_iter", 32'(iter_count), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Directed values fixed from the algorithm definitions
    do_op(16'd12, 16'd8, 1'b0, 0, g, e, it, lat);
    check_val("sub12_8_gcd", 32'(g), 32'd4);
    check_val("sub12_8_err", 32'(e), 32'd0);
    check_val("sub12_8_iter", 32'(it), 32'd3);
    check_val("sub12_8_lat", 32'(lat), 32'd5);
    do_op(16'd12, 16'd8, 1'b1, 0, g, e, it, lat);
    check_val("stein12_8_gcd", 32'(g), 32'd4);
    check_val("stein12_8_iter", 32'(it), 32'd8);
    check_val("stein12_8_lat", 32'(lat), 32'd10);
    do_op(16'd0, 16'd9, 1'b1, 0, g, e, it, lat);
    check_val("zero_b_gcd", 32'(g), 32'd9);
    check_val("zero_b_err", 32'(e), 32'd0);
    check_val("zero_b_iter", 32'(it), 32'd0);
    check_val("zero_b_lat", 32'(lat), 32'd2);
    do_op(16'd0, 16'd0, 1'b0, 0, g, e, it, lat);
    check_val("zero_ab_gcd", 32'(g), 32'd0);
    check_val("zero_ab_err", 32'(e), 32'd1);
    check_val("zero_ab_lat", 32'(lat), 32'd2);

    // Backpressure: result held, new requests and abort ignored while in DONE
    @(negedge clk);
    in_valid = 1'b1;
    a_in     = 16'd21;
    b_in     = 16'd14;
    mode_in  = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_done(BUDGET, lat);
    check_val("bp_lat", 32'(lat), 32'(ref_iter(21, 14, 1'b0) + 2));
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      abort    = 1'b1;
      a_in     = 16'(i + 3);
      b_in     = 16'd1;
      @(negedge clk);
      check_val("bp_hold_valid", 32'(out_valid), 32'd1);
      check_val("bp_hold_gcd", 32'(gcd_out), 32'd7);
      check_val("bp_hold_in_ready", 32'(in_ready), 32'd0);
    end
    abort = 1'b0;
    // Release together with a new request: the request waits for the IDLE cycle
    out_ready = 1'b1;
    a_in      = 16'd9;
    b_in      = 16'd6;
    mode_in   = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_val("bp_rel_valid", 32'(out_valid), 32'd0);
    check_val("bp_rel_in_ready", 32'(in_ready), 32'd1);
    check_val("bp_rel_gcd_kept", 32'(gcd_out), 32'd7);
    @(negedge clk);
    in_valid = 1'b0;
    check_val("bp_next_accepted", 32'(in_ready), 32'd0);
    wait_done(BUDGET, lat);
    check_val("bp_next_gcd", 32'(gcd_out), 32'd3);
    check_val("bp_next_iter", 32'(iter_count), 32'(ref_iter(9, 6, 1'b1)));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Abort a long subtractive run
    in_valid = 1'b1;
    a_in     = 16'd65535;
    b_in     = 16'd1;
    mode_in  = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(negedge clk);
    check_val("abort_busy", 32'(in_ready), 32'd0);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    check_val("abort_in_ready", 32'(in_ready), 32'd1);
    check_val("abort_valid", 32'(out_valid), 32'd0);
    check_val("abort_gcd_kept", 32'(gcd_out), 32'd3);
    repeat (3) @(negedge clk);
    check_val("abort_still_idle", 32'(out_valid), 32'd0);
    do_op(16'd48, 16'd18, 1'b0, 0, g, e, it, lat);
    check_val("post_abort_gcd", 32'(g), 32'd6);
    check_val("post_abort_iter", 32'(it), 32'd5);

    // Asynchronous reset in the middle of a binary run
    @(negedge clk);
    in_valid = 1'b1;
    a_in     = 16'd96;
    b_in     = 16'd45;
    mode_in  = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check_val("mid_stein_busy", 32'(in_ready), 32'd0);
    #2 rst = 1'b0;
    #1;
    check_val("arst_in_ready", 32'(in_ready), 32'd1);
    check_val("arst_valid", 32'(out_valid), 32'd0);
    check_val("arst_gcd", 32'(gcd_out), 32'd0);
    check_val("arst_iter", 32'(iter_count), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    do_op(16'd35, 16'd14, 1'b1, 0, g, e, it, lat);
    check_val("post_rst_gcd", 32'(g), 32'd7);
    check_val("post_rst_iter", 32'(it), 32'(ref_iter(35, 14, 1'b1)));

    // Randomized 8-bit operands, both algorithms, with occasional zeros and output stalls
    for (int i = 0; i < 1000 && n_err < 20; i++) begin
      ra = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 255));
      rb = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 255));
      rm = 1'($urandom_range(0, 1));
      if (i % 3 == 0) begin
        run_check("rnd", ra, rb, rm);
      end else begin
        do_op(16'(ra), 16'(rb), rm, int'($urandom_range(0, 2)), g, e, it, lat);
        check_val("rnd_gcd", 32'(g), 32'(ref_gcd(ra, rb)));
        check_val("rnd_err", 32'(e), 32'(ra == 0 && rb == 0));
        check_val("rnd_iter", 32'(it), 32'(ref_iter(ra, rb, rm)));
        check_val("rnd_lat", 32'(lat), 32'(ref_iter(ra, rb, rm) + 2));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
